fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit and its environment (program counter,
// instruction memory and decode).
//   master : the fetch unit itself (drives pc_inc, mem_rd/mem_addr, ir/ir_pc/ir_valid, fetch_err)
//   slave  : the environment (drives fetch_en, flush, pc_in, mem_rdata/mem_ready, ir_ready)
interface fetch_unit_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  logic              fetch_en;
  logic              flush;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_inc;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              fetch_err;

  modport master (
    input  fetch_en, flush, pc_in, mem_rdata, mem_ready, ir_ready,
    output pc_inc, mem_rd, mem_addr, ir, ir_pc, ir_valid, fetch_err
  );

  modport slave (
    output fetch_en, flush, pc_in, mem_rdata, mem_ready, ir_ready,
    input  pc_inc, mem_rd, mem_addr, ir, ir_pc, ir_valid, fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory read per instruction, holds the
// fetched word until decode accepts it, and flags a sticky error when memory
// does not answer within TIMEOUT_CYCLES wait cycles.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - fetch_unit_if.master: PC handshake (pc_in/pc_inc), memory read
//           (mem_rd/mem_addr/mem_rdata/mem_ready), decode handshake
//           (ir/ir_pc/ir_valid/ir_ready), control (fetch_en/flush) and fetch_err.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              pc_inc_nxt, mem_rd_nxt, ir_valid_nxt, fetch_err_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt, ir_pc_nxt;
  logic [DATA_W-1:0] ir_nxt;
  logic              issue;

  // Next-state and next-output logic; flush overrides everything else.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_inc_nxt    = 1'b0;
    mem_rd_nxt    = bus.mem_rd;
    mem_addr_nxt  = bus.mem_addr;
    ir_nxt        = bus.ir;
    ir_pc_nxt     = bus.ir_pc;
    ir_valid_nxt  = bus.ir_valid;
    fetch_err_nxt = bus.fetch_err;
    issue         = 1'b0;

    if (bus.flush) begin
      state_nxt     = ST_IDLE;
      cnt_nxt       = '0;
      mem_rd_nxt    = 1'b0;
      ir_valid_nxt  = 1'b0;
      fetch_err_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: issue = bus.fetch_en;
        ST_WAIT: begin
          if (bus.mem_ready) begin
            state_nxt    = ST_HOLD;
            ir_nxt       = bus.mem_rdata;
            ir_pc_nxt    = bus.mem_addr;
            ir_valid_nxt = 1'b1;
            mem_rd_nxt   = 1'b0;
          end else if (cnt == CNT_LAST) begin
            state_nxt     = ST_ERR;
            fetch_err_nxt = 1'b1;
            mem_rd_nxt    = 1'b0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.ir_ready) begin
            ir_valid_nxt = 1'b0;
            if (bus.fetch_en) begin
              issue = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        ST_ERR: begin
          mem_rd_nxt   = 1'b0;
          ir_valid_nxt = 1'b0;
        end
        default: state_nxt = ST_IDLE;
      endcase

      // Issue path shared by IDLE and HOLD: pc_in is only sampled here.
      if (issue) begin
        state_nxt    = ST_WAIT;
        mem_addr_nxt = bus.pc_in;
        mem_rd_nxt   = 1'b1;
        pc_inc_nxt   = 1'b1;
        cnt_nxt      = '0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bus.pc_inc    <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.ir        <= '0;
      bus.ir_pc     <= '0;
      bus.ir_valid  <= 1'b0;
      bus.fetch_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.pc_inc    <= pc_inc_nxt;
      bus.mem_rd    <= mem_rd_nxt;
      bus.mem_addr  <= mem_addr_nxt;
      bus.ir        <= ir_nxt;
      bus.ir_pc     <= ir_pc_nxt;
      bus.ir_valid  <= ir_valid_nxt;
      bus.fetch_err <= fetch_err_nxt;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized traffic.
// The driver pushes the expected instruction (address, memory image word) on
// every issued fetch; a separate monitor pops and compares each instruction
// presented to decode and checks the handshake rules cycle by cycle, using
// only the architectural view (idle / waiting / holding / error) seen at the
// outputs.
module tb_fetch_unit;
  localparam int TO = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic reset;
  fetch_unit_if bus ();

  fetch_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   rst_gen  = 0;
  int   lat      = 0;
  exp_t exp_q[$];
  logic [15:0] mem_img [logic [15:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: explicit image entries, otherwise a fixed scramble of the address.
  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Advance one cycle; record the expectation for any fetch issued at this edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #2;
    if (bus.pc_inc) begin
      e.pc   = bus.pc_in;
      e.data = rd(bus.pc_in);
      exp_q.push_back(e);
    end
    bus.mem_rdata = rd(bus.mem_addr);
  endtask

  task automatic rand_step(input bit allow_fetch, input bit allow_flush);
    tick();
    if (bus.mem_rd) begin
      if (bus.pc_inc) lat = (($urandom % 10) == 0) ? 255 : int'($urandom % 4);
      bus.mem_ready = (lat == 0);
      if (lat > 0) lat--;
      if (!bus.mem_ready) bus.mem_rdata = 16'($urandom);
    end else begin
      bus.mem_ready = (($urandom % 4) == 0);
      bus.mem_rdata = 16'($urandom);
    end
    bus.fetch_en = allow_fetch && (($urandom % 4) != 0);
    bus.ir_ready = !allow_fetch || (($urandom % 3) != 0);
    bus.flush    = allow_flush && (($urandom % 30) == 0);
    bus.pc_in    = 16'($urandom);
    if (bus.flush) exp_q.delete();
  endtask

  // Monitor: runs 1 time unit after each edge, when the inputs on the bus are
  // still the ones that edge sampled.
  initial begin
    logic        p_mem_rd, p_ir_valid, p_err, shown, exp_issue;
    logic [15:0] p_addr, p_ir, p_ir_pc;
    int          wait_cnt, rst_seen;
    exp_t        e;
    p_mem_rd = 0; p_ir_valid = 0; p_err = 0; shown = 0;
    p_addr = '0; p_ir = '0; p_ir_pc = '0;
    wait_cnt = 0; rst_seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (rst_seen != rst_gen) begin
          p_mem_rd = 0; p_ir_valid = 0; p_err = 0; shown = 0;
          p_addr = '0; p_ir = '0; p_ir_pc = '0;
          wait_cnt = 0; rst_seen = rst_gen;
        end
        exp_issue = bus.fetch_en && !bus.flush && !p_err && !p_mem_rd &&
                    (!p_ir_valid || bus.ir_ready);
        chk("pc_inc", 64'(bus.pc_inc), 64'(exp_issue));

        if (bus.flush) begin
          chk("flush_clear", 64'({bus.mem_rd, bus.ir_valid, bus.fetch_err}), 64'(0));
          chk("flush_ir", 64'(bus.ir), 64'(p_ir));
          shown = 0;
        end else if (p_err) begin
          chk("err_hold", 64'({bus.mem_rd, bus.ir_valid, bus.fetch_err}), 64'(3'b001));
        end else if (p_mem_rd) begin
          if (bus.mem_ready) begin
            chk("complete", 64'({bus.ir_valid, bus.mem_rd}), 64'(2'b10));
          end else begin
            wait_cnt++;
            if (wait_cnt == TO) begin
              chk("timeout", 64'({bus.fetch_err, bus.mem_rd}), 64'(2'b10));
              if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
              chk("wait_stable", 64'({bus.mem_rd, bus.mem_addr, bus.fetch_err}),
                  64'({1'b1, p_addr, 1'b0}));
            end
          end
        end else if (p_ir_valid) begin
          if (bus.ir_ready) begin
            chk("consume", 64'(bus.ir_valid), 64'(0));
            shown = 0;
          end else begin
            chk("hold_stable", 64'({bus.ir_valid, bus.ir, bus.ir_pc}),
                64'({1'b1, p_ir, p_ir_pc}));
          end
        end else if (!bus.pc_inc) begin
          chk("idle", 64'({bus.mem_rd, bus.ir_valid, bus.fetch_err}), 64'(0));
        end

        if (bus.pc_inc) begin
          chk("issue", 64'({bus.mem_rd, bus.mem_addr, bus.ir_valid}),
              64'({1'b1, bus.pc_in, 1'b0}));
          wait_cnt = 0;
        end

        if (bus.ir_valid && !shown) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ir", 64'(bus.ir_pc), 64'(17'h1ffff));
          end else begin
            e = exp_q.pop_front();
            chk("ir_data", 64'(bus.ir), 64'(e.data));
            chk("ir_pc", 64'(bus.ir_pc), 64'(e.pc));
          end
          shown = 1;
        end

        p_mem_rd = bus.mem_rd; p_ir_valid = bus.ir_valid; p_err = bus.fetch_err;
        p_addr = bus.mem_addr; p_ir = bus.ir; p_ir_pc = bus.ir_pc;
      end
    end
  end

  // Driver: directed scenarios, then random traffic, then drain.
  initial begin
    reset = 1'b1;
    bus.fetch_en = 0; bus.flush = 0; bus.pc_in = '0; bus.mem_rdata = '0;
    bus.mem_ready = 0; bus.ir_ready = 0;
    mem_img[16'h3000] = 16'h1234;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_vals", 64'({bus.pc_inc, bus.mem_rd, bus.mem_addr, bus.ir, bus.ir_pc,
                          bus.ir_valid, bus.fetch_err}), 64'(0));
    reset = 1'b0;

    // Basic fetch with memory answering in the first wait cycle.
    bus.pc_in = 16'h3000; bus.fetch_en = 1; bus.mem_ready = 1;
    tick();
    chk("basic_issue", 64'({bus.pc_inc, bus.mem_rd, bus.mem_addr}), 64'({2'b11, 16'h3000}));
    bus.pc_in = 16'h3001;
    tick();
    chk("basic_ir", 64'({bus.ir_valid, bus.ir, bus.ir_pc, bus.pc_inc}),
        64'({1'b1, 16'h1234, 16'h3000, 1'b0}));
    bus.mem_ready = 0;

    // Back-pressure: decode stalls for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", 64'({bus.ir_valid, bus.ir, bus.mem_rd, bus.pc_inc}),
          64'({1'b1, 16'h1234, 2'b00}));
    end
    bus.ir_ready = 1;
    tick();
    chk("bp_release", 64'({bus.pc_inc, bus.mem_rd, bus.mem_addr, bus.ir_valid}),
        64'({2'b11, 16'h3001, 1'b0}));

    // Wait states: memory answers after 3 idle wait cycles.
    bus.fetch_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_wait", 64'({bus.mem_rd, bus.mem_addr, bus.ir_valid}), 64'({1'b1, 16'h3001, 1'b0}));
    end
    bus.mem_ready = 1;
    tick();
    chk("ws_ir", 64'({bus.ir_valid, bus.ir_pc, bus.ir, bus.mem_rd}),
        64'({1'b1, 16'h3001, rd(16'h3001), 1'b0}));
    bus.mem_ready = 0;
    tick();
    chk("ws_drain", 64'({bus.ir_valid, bus.pc_inc}), 64'(0));

    // Flush coincident with read data; redirect to 0x4000.
    bus.pc_in = 16'h3002; bus.fetch_en = 1;
    tick();
    bus.flush = 1; bus.mem_ready = 1; bus.pc_in = 16'h4000;
    exp_q.delete();
    tick();
    chk("flush_kill", 64'({bus.ir_valid, bus.mem_rd, bus.pc_inc, bus.ir, bus.fetch_err}),
        64'({3'b000, rd(16'h3001), 1'b0}));
    bus.flush = 0; bus.mem_ready = 0;
    tick();
    chk("flush_redirect", 64'({bus.pc_inc, bus.mem_addr}), 64'({1'b1, 16'h4000}));
    bus.mem_ready = 1; bus.fetch_en = 0;
    tick();
    chk("redirect_ir", 64'({bus.ir_valid, bus.ir_pc}), 64'({1'b1, 16'h4000}));
    bus.mem_ready = 0;
    tick();

    // Timeout: no answer from memory.
    bus.pc_in = 16'h5000; bus.fetch_en = 1;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("to_wait", 64'({bus.fetch_err, bus.mem_rd}), 64'(2'b01));
    end
    tick();
    chk("to_err", 64'({bus.fetch_err, bus.mem_rd}), 64'(2'b10));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_sticky", 64'({bus.fetch_err, bus.mem_rd, bus.pc_inc, bus.ir_valid}), 64'(4'b1000));
    end
    bus.flush = 1;
    exp_q.delete();
    tick();
    chk("err_flush", 64'({bus.fetch_err, bus.pc_inc}), 64'(0));
    bus.flush = 0; bus.fetch_en = 0;

    // Asynchronous reset pulse between edges while waiting on memory.
    bus.pc_in = 16'h6000; bus.fetch_en = 1;
    tick();
    chk("rst_pre", 64'({bus.pc_inc, bus.mem_rd}), 64'(2'b11));
    bus.fetch_en = 0;
    #3;
    reset = 1'b1;
    rst_gen++;
    exp_q.delete();
    #1;
    chk("rst_async", 64'({bus.pc_inc, bus.mem_rd, bus.mem_addr, bus.ir, bus.ir_pc,
                         bus.ir_valid, bus.fetch_err}), 64'(0));
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_quiet", 64'({bus.pc_inc, bus.mem_rd}), 64'(0));
    end
    bus.fetch_en = 1; bus.pc_in = 16'h6001;
    tick();
    chk("rst_refetch", 64'({bus.pc_inc, bus.mem_addr}), 64'({1'b1, 16'h6001}));
    bus.mem_ready = 1; bus.fetch_en = 0;
    tick();
    bus.mem_ready = 0;
    tick();

    // Randomized traffic, then drain without new fetches.
    lat = 0;
    for (int i = 0; i < 3000; i++) rand_step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) rand_step(1'b0, 1'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
